// File: rtl/debounce_pkg.sv
// Shared constants and level encoding for the switch debouncer.
// The optional press-toggle output is built only when DEBOUNCE_TOGGLE_EN is defined.
package debounce_pkg;

    localparam int DEFAULT_STABLE_CYCLES = 1000000;
    localparam int SIM_STABLE_CYCLES     = 4;

    typedef enum logic {
        LVL_LOW  = 1'b0,
        LVL_HIGH = 1'b1
    } level_e;

endpackage

// File: rtl/switch_debouncer_if.sv
// Pin-side input and debounced outputs of the switch debouncer.
// There is no valid/ready pair: db_level is a level, db_rise/db_fall are one-cycle strobes.
interface switch_debouncer_if;

    logic raw_in;
    logic db_level;
    logic db_rise;
    logic db_fall;
    logic toggle_q;

    modport master (
        output raw_in,
        input  db_level,
        input  db_rise,
        input  db_fall,
        input  toggle_q
    );

    modport slave (
        input  raw_in,
        output db_level,
        output db_rise,
        output db_fall,
        output toggle_q
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit; both flops reset to RST_VAL.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Nothing may sit between the two flops so the first one can settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces one raw switch input into a clean level plus rise/fall strobes.
// Define DEBOUNCE_TOGGLE_EN to build the press-toggle flop behind toggle_q.
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    switch_debouncer_if.slave  dbif
);

    localparam int             CW      = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic          sync_q;
    level_e        sync_level;
    level_e        level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    sync_2ff #(
        .RST_VAL (RESET_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dbif.raw_in),
        .q     (sync_q)
    );

    assign sync_level = level_e'(sync_q);

    // Any cycle matching the current level wipes the count: no partial credit.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_level != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync_level;
                rise_d  = (sync_level == LVL_HIGH);
                fall_d  = (sync_level == LVL_LOW);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= level_e'(RESET_LEVEL);
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign dbif.db_level = (level_q == LVL_HIGH);
    assign dbif.db_rise  = rise_q;
    assign dbif.db_fall  = fall_q;

`ifdef DEBOUNCE_TOGGLE_EN
    logic tog_q, tog_d;

    // Flips on the same edge that raises db_rise, so both change together.
    always_comb begin
        tog_d = tog_q ^ rise_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tog_q <= 1'b0;
        end else begin
            tog_q <= tog_d;
        end
    end

    assign dbif.toggle_q = tog_q;
`else
    assign dbif.toggle_q = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with STABLE_CYCLES=4, RESET_LEVEL=0.
// toggle_q expectations follow DEBOUNCE_TOGGLE_EN.
module tb_switch_debouncer;
  import debounce_pkg::*;

  localparam int W   = 20;
  localparam int LAT = 6;  // 2 sync edges + 4 stable cycles

  // ---------------- clock / reset ----------------
  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  int unsigned cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  switch_debouncer_if dbif();

  switch_debouncer #(
    .STABLE_CYCLES (SIM_STABLE_CYCLES),
    .RESET_LEVEL   (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dbif  (dbif)
  );

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       exp_tog  = 1'b0;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] pack_ev(int unsigned c, logic lvl, logic r, logic f, logic t);
    logic [15:0] c16;
    c16 = c[15:0];
    return {c16, lvl, r, f, t};
  endfunction

  function automatic logic [3:0] outs();
    return {dbif.db_level, dbif.db_rise, dbif.db_fall, dbif.toggle_q};
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {lvl,rise,fall,tog}=%b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_raw(input logic v);
    @(negedge clk);
    dbif.raw_in = v;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Push the strobe expected LAT edges after the edge that first samples the new value.
  task automatic expect_edge(input logic is_rise);
`ifdef DEBOUNCE_TOGGLE_EN
    if (is_rise) exp_tog = ~exp_tog;
`endif
    exp_q.push_back(pack_ev(cyc + LAT, is_rise, is_rise, ~is_rise, exp_tog));
  endtask

  task automatic transition(input logic v, input string name);
    set_raw(v);
    expect_edge(v);
    wait_cycles(LAT - 1);
    check({name, "_early"}, {3'b000, dbif.db_level}, {3'b000, ~v});
    wait_cycles(1);
    check({name, "_level"}, {3'b000, dbif.db_level}, {3'b000, v});
    wait_cycles(4);
    check({name, "_steady"}, outs(), {v, 1'b0, 1'b0, exp_tog});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && (dbif.db_rise || dbif.db_fall)) begin
      logic [W-1:0] exp_ev;
      logic [W-1:0] act_ev;
      n_checks++;
      act_ev = pack_ev(cyc, dbif.db_level, dbif.db_rise, dbif.db_fall, dbif.toggle_q);
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got {cyc,lvl,rise,fall,tog}=%h, expected no strobe", act_ev);
      end else begin
        exp_ev = exp_q.pop_front();
        if (act_ev !== exp_ev) begin
          n_fail++;
          $display("FAIL strobe: got {cyc,lvl,rise,fall,tog}=%h, expected %h", act_ev, exp_ev);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    dbif.raw_in = 1'b1;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reset_hold", outs(), 4'b0000);
    end

    @(negedge clk);
    dbif.raw_in = 1'b0;
    rst_n       = 1'b1;
    wait_cycles(4);
    check("idle_after_reset", outs(), 4'b0000);

    transition(1'b1, "press");
    transition(1'b0, "release");

    for (int i = 0; i < 5; i++) begin
      set_raw(1'b1);
      set_raw(1'b1);
      set_raw(1'b1);
      set_raw(1'b0);
    end
    wait_cycles(3);
    check("bounce_no_change", outs(), {1'b0, 1'b0, 1'b0, exp_tog});
    transition(1'b1, "bounce_press");
    transition(1'b0, "bounce_release");

    transition(1'b1, "press3");
    transition(1'b0, "release3");

    // Press, then reset between edges once the counter has reached 2.
    set_raw(1'b1);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", outs(), 4'b0000);
    exp_tog = 1'b0;
    wait_cycles(2);
    check("reset_mid_hold", outs(), 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    expect_edge(1'b1);
    wait_cycles(LAT - 1);
    check("reset_no_credit", {3'b000, dbif.db_level}, 4'b0000);
    wait_cycles(1);
    check("reset_then_rise", {3'b000, dbif.db_level}, 4'b0001);
    wait_cycles(4);
    check("reset_then_steady", outs(), {1'b1, 1'b0, 1'b0, exp_tog});

    wait_cycles(2);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_strobes: got %0d outstanding, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
